hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 16-bit five-stage core.
- Generates the ForwardA/ForwardB selects that drive the EX-stage ALU operand muxes.
- Detects load-use hazards, flushes on taken branches, and freezes or bubbles stages while instruction or data memory is busy.
- Holds stall state across cycles: a pending-redirect flag and saturating performance counters.
- Sits beside the pipeline registers and drives their write-enable and flush inputs.

---
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard and stall controller for the 16-bit five-stage core.
//
// Drives the EX-stage operand forwarding selects and the write-enable and flush
// inputs of the pipeline registers. Responds to data-memory freezes, taken
// branches, load-use hazards and instruction-fetch stalls, in that priority.
// Keeps a pending-redirect flag for a branch whose target fetch has to wait on
// a busy instruction memory. Also keeps two saturating performance counters.
//
// Ports:
//   clk, rst_n                     core clock, asynchronous active-low reset
//   id_rs, id_rt                   sources of the instruction in ID
//   ex_rs, ex_rt, ex_rd            sources and destination of the instruction in EX
//   ex_memread                     EX instruction is a load
//   mem_rd, mem_regwrite           MEM-stage destination and write flag
//   wb_rd, wb_regwrite             WB-stage destination and write flag
//   branch_taken                   EX resolved a taken branch or jump
//   imem_busy, dmem_busy           memory-busy indications
//   cnt_clr                        synchronous clear of both counters
//   ForwardA, ForwardB             00 regfile, 01 WB data, 10 MEM ALU result
//   pc_we .. exmem_we              pipeline-register write enables
//   ifid_flush .. memwb_flush      bubble insertion
//   stall_cnt, flush_cnt           cycles with pc_we=0, counted branch flushes
module hazard_ctrl #(
    parameter int NREG_BITS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREG_BITS-1:0] id_rs,
    input  logic [NREG_BITS-1:0] id_rt,
    input  logic [NREG_BITS-1:0] ex_rs,
    input  logic [NREG_BITS-1:0] ex_rt,
    input  logic [NREG_BITS-1:0] ex_rd,
    input  logic                 ex_memread,
    input  logic [NREG_BITS-1:0] mem_rd,
    input  logic                 mem_regwrite,
    input  logic [NREG_BITS-1:0] wb_rd,
    input  logic                 wb_regwrite,
    input  logic                 branch_taken,
    input  logic                 imem_busy,
    input  logic                 dmem_busy,
    input  logic                 cnt_clr,
    output logic [1:0]           ForwardA,
    output logic [1:0]           ForwardB,
    output logic                 pc_we,
    output logic                 ifid_we,
    output logic                 idex_we,
    output logic                 exmem_we,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_flush,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef enum logic [1:0] {RUN, DSTALL, ISTALL} state_t;

    state_t          state_reg, state_next;
    logic            redirect_pending_reg, redirect_pending_next;
    logic            branch_seen_reg, branch_seen_next;
    logic [1:0]      fwd_a_hold_reg, fwd_b_hold_reg;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    logic [1:0] fwd_a_live, fwd_b_live;
    logic       load_use, branch_eff, flush_event, fwd_frozen;

    // MEM has priority over WB. A destination of r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [NREG_BITS-1:0] src,
        input logic [NREG_BITS-1:0] m_rd,
        input logic                 m_we,
        input logic [NREG_BITS-1:0] w_rd,
        input logic                 w_we
    );
        if (m_we && m_rd != '0 && m_rd == src)
            return 2'b10;
        else if (w_we && w_rd != '0 && w_rd == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a_live = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign fwd_b_live = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

    // From the second busy cycle on, MEM/WB no longer hold what the frozen EX
    // instruction was paired with, so the selects are replayed from the
    // first frozen cycle.
    assign fwd_frozen = dmem_busy && (state_reg == DSTALL);
    assign load_use   = ex_memread && (ex_rd != '0) && (ex_rd == id_rs || ex_rd == id_rt);
    // A branch observed during a freeze is remembered until the freeze lifts.
    assign branch_eff = branch_taken || branch_seen_reg;

    always_comb begin
        pc_we                 = 1'b1;
        ifid_we               = 1'b1;
        idex_we               = 1'b1;
        exmem_we              = 1'b1;
        ifid_flush            = 1'b0;
        idex_flush            = 1'b0;
        memwb_flush           = 1'b0;
        ForwardA              = fwd_frozen ? fwd_a_hold_reg : fwd_a_live;
        ForwardB              = fwd_frozen ? fwd_b_hold_reg : fwd_b_live;
        flush_event           = 1'b0;
        redirect_pending_next = redirect_pending_reg;
        branch_seen_next      = 1'b0;
        state_next            = dmem_busy ? DSTALL : (imem_busy ? ISTALL : RUN);

        if (dmem_busy) begin
            pc_we            = 1'b0;
            ifid_we          = 1'b0;
            idex_we          = 1'b0;
            exmem_we         = 1'b0;
            memwb_flush      = 1'b1;
            ifid_flush       = redirect_pending_reg;
            branch_seen_next = branch_eff;
        end else if (branch_eff) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            // A branch repeated while a redirect is already pending is the
            // same redirect, so it is not counted again.
            flush_event = !redirect_pending_reg;
            if (imem_busy) begin
                pc_we                 = 1'b0;
                redirect_pending_next = 1'b1;
            end else begin
                redirect_pending_next = 1'b0;
            end
        end else begin
            if (load_use) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end else if (imem_busy) begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
            end
            // The fetch returning in the clearing cycle is still wrong-path.
            if (redirect_pending_reg) begin
                ifid_flush = 1'b1;
                if (!imem_busy) begin
                    pc_we                 = 1'b1;
                    redirect_pending_next = 1'b0;
                end
            end
        end

        // Reset forces the safe pipeline state immediately, not at the next edge.
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            ForwardA    = 2'b00;
            ForwardB    = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= RUN;
            redirect_pending_reg <= 1'b0;
            branch_seen_reg      <= 1'b0;
            fwd_a_hold_reg       <= 2'b00;
            fwd_b_hold_reg       <= 2'b00;
            stall_cnt_reg        <= '0;
            flush_cnt_reg        <= '0;
        end else begin
            state_reg            <= state_next;
            redirect_pending_reg <= redirect_pending_next;
            branch_seen_reg      <= branch_seen_next;
            fwd_a_hold_reg       <= ForwardA;
            fwd_b_hold_reg       <= ForwardB;
            if (cnt_clr) begin
                stall_cnt_reg <= '0;
                flush_cnt_reg <= '0;
            end else begin
                if (!pc_we && stall_cnt_reg != '1)
                    stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
                if (flush_event && flush_cnt_reg != '1)
                    flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Each driven cycle pushes its expected
// control word, forwarding selects and counter values onto a scoreboard; a
// negative-edge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

    localparam logic [6:0] C_RUN   = 7'b1111_000;
    localparam logic [6:0] C_RST   = 7'b0000_111;
    localparam logic [6:0] C_FRZ   = 7'b0000_001;
    localparam logic [6:0] C_LU    = 7'b0011_010;
    localparam logic [6:0] C_BR    = 7'b1111_110;
    localparam logic [6:0] C_BRIB  = 7'b0111_110;
    localparam logic [6:0] C_IB    = 7'b0111_100;
    localparam logic [6:0] C_REDIR = 7'b1111_100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        ex_memread, mem_regwrite, wb_regwrite;
    logic        branch_taken, imem_busy, dmem_busy, cnt_clr;
    logic [1:0]  ForwardA, ForwardB;
    logic        pc_we, ifid_we, idex_we, exmem_we;
    logic        ifid_flush, idex_flush, memwb_flush;
    logic [15:0] stall_cnt, flush_cnt;
    logic [6:0]  ctl_now;

    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [3:0]  fwd;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_stall = 16'h0;
    logic [15:0] exp_flush = 16'h0;

    hazard_ctrl #(.NREG_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .cnt_clr(cnt_clr),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctl_now = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with inputs already set: records the expectation for
    // this cycle, advances the expected counters past the next edge, then waits
    // for that edge.
    task automatic cycle(input string tag, input logic [6:0] ctl, input logic [3:0] fwd,
                         input bit clr, input bit fev);
        exp_t e;
        cnt_clr = clr;
        e.tag  = tag;
        e.ctl  = ctl;
        e.fwd  = fwd;
        e.scnt = exp_stall;
        e.fcnt = exp_flush;
        sb.push_back(e);
        if (clr) begin
            exp_stall = 16'h0;
            exp_flush = 16'h0;
        end else begin
            if (!ctl[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'h1;
            if (fev && exp_flush != 16'hFFFF)     exp_flush = exp_flush + 16'h1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
        branch_taken = 0; imem_busy = 0; dmem_busy = 0; cnt_clr = 0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("txn %s ctl=%b fwd=%b%b stall=%h flush=%h",
                     e.tag, ctl_now, ForwardA, ForwardB, stall_cnt, flush_cnt);
            check({e.tag, "_ctl"},   {25'd0, ctl_now},          {25'd0, e.ctl});
            check({e.tag, "_fwd"},   {28'd0, ForwardA, ForwardB}, {28'd0, e.fwd});
            check({e.tag, "_stall"}, {16'd0, stall_cnt},         {16'd0, e.scnt});
            check({e.tag, "_flush"}, {16'd0, flush_cnt},         {16'd0, e.fcnt});
        end
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("rst_ctl",   {25'd0, ctl_now}, {25'd0, C_RST});
        check("rst_fwd",   {28'd0, ForwardA, ForwardB}, 32'd0);
        check("rst_stall", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Forwarding
        mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1; ex_rs = 3; ex_rt = 5;
        cycle("fwd_mem", C_RUN, 4'b1000, 0, 0);
        mem_rd = 0;
        cycle("fwd_wb", C_RUN, 4'b0100, 0, 0);
        ex_rt = 3;
        cycle("fwd_wb_b", C_RUN, 4'b0101, 0, 0);
        mem_rd = 5; ex_rt = 5;
        cycle("fwd_mix", C_RUN, 4'b0110, 0, 0);
        wb_regwrite = 0;
        cycle("fwd_nowb", C_RUN, 4'b0010, 0, 0);
        mem_rd = 0; wb_rd = 0; wb_regwrite = 1; ex_rs = 0; ex_rt = 0;
        cycle("fwd_r0", C_RUN, 4'b0000, 0, 0);
        idle_inputs();

        // Load-use
        ex_memread = 1; ex_rd = 4; id_rt = 4;
        cycle("lu", C_LU, 4'b0000, 0, 0);
        ex_memread = 0;
        cycle("lu_after", C_RUN, 4'b0000, 0, 0);
        ex_memread = 1; ex_rd = 0; id_rs = 0; id_rt = 0;
        cycle("lu_r0", C_RUN, 4'b0000, 0, 0);
        idle_inputs();

        // Plain branch, then branch during a fetch stall
        branch_taken = 1;
        cycle("br", C_BR, 4'b0000, 0, 1);
        branch_taken = 0;
        cycle("br_after", C_RUN, 4'b0000, 0, 0);
        branch_taken = 1; imem_busy = 1;
        for (int i = 0; i < 3; i++)
            cycle("br_ib", C_BRIB, 4'b0000, 0, i == 0);
        branch_taken = 0; imem_busy = 0;
        cycle("br_redir", C_REDIR, 4'b0000, 0, 0);
        cycle("br_done", C_RUN, 4'b0000, 0, 0);

        // Data stall outranks branch and load-use; branch acted on once afterwards
        ex_rs = 3; mem_rd = 3; mem_regwrite = 1; dmem_busy = 1; branch_taken = 1;
        ex_memread = 1; ex_rd = 4; id_rt = 4;
        cycle("dstall", C_FRZ, 4'b1000, 0, 0);
        mem_rd = 7;
        for (int i = 0; i < 3; i++)
            cycle("dstall_hold", C_FRZ, 4'b1000, 0, 0);
        dmem_busy = 0;
        cycle("dstall_br", C_BR, 4'b0000, 0, 1);
        branch_taken = 0; ex_memread = 0;
        cycle("dstall_done", C_RUN, 4'b0000, 0, 0);
        idle_inputs();

        // Saturation and clear
        cycle("clr", C_RUN, 4'b0000, 1, 0);
        cnt_clr = 0; imem_busy = 1;
        repeat (65534) @(posedge clk);
        #1;
        exp_stall = 16'hFFFE;
        for (int i = 0; i < 3; i++)
            cycle("sat", C_IB, 4'b0000, 0, 0);
        cycle("sat_clr", C_IB, 4'b0000, 1, 0);
        imem_busy = 0;
        cycle("after_clr", C_RUN, 4'b0000, 0, 0);

        // Asynchronous reset while a redirect is pending in ISTALL
        branch_taken = 1; imem_busy = 1;
        cycle("pre_rst", C_BRIB, 4'b0000, 0, 1);
        #6;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl",   {25'd0, ctl_now}, {25'd0, C_RST});
        check("async_rst_stall", {16'd0, stall_cnt}, 32'd0);
        check("async_rst_flush", {16'd0, flush_cnt}, 32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_stall = 16'h0;
        exp_flush = 16'h0;
        cycle("post_rst", C_RUN, 4'b0000, 0, 0);
        cycle("post_rst2", C_RUN, 4'b0000, 0, 0);
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
